// File: rtl/rv32i_single_cycle_core.sv
// Single-cycle RV32I core with a private unified word memory and a flat
// 4096-entry machine-mode CSR file. Every instruction (including traps and
// CSR updates) retires in one clock. Fetch and load data are combinational
// reads of the memory; pc, register, CSR and memory writes commit on posedge.
// There is no handshake anywhere: the core advances unconditionally each clock.

// Unified instruction/data memory: two combinational read ports, one
// byte-lane write port. Contents survive reset so a preloaded program stays.
module rv32i_single_cycle_core_mem #(
   parameter int WORDS = 65536,
   parameter int AW    = 16
) (
   input  logic          clk,
   input  logic [AW-1:0] iaddr,
   output logic [31:0]   idata,
   input  logic [AW-1:0] daddr,
   output logic [31:0]   rdata,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [31:0]   wdata
);
   logic [31:0] m [0:WORDS-1];

   assign idata = m[iaddr];
   assign rdata = m[daddr];

   // Byte-lane store: only the enabled lanes of the addressed word change.
   always_ff @(posedge clk) begin
      if (we) begin
         if (be[0]) m[daddr][7:0]   <= wdata[7:0];
         if (be[1]) m[daddr][15:8]  <= wdata[15:8];
         if (be[2]) m[daddr][23:16] <= wdata[23:16];
         if (be[3]) m[daddr][31:24] <= wdata[31:24];
      end
   end
endmodule

module rv32i_single_cycle_core #(
   parameter int          MEM_WORDS = 65536,
   parameter logic [31:0] RESET_PC  = 32'h0
) (
   input logic clk,
   input logic rst
);
   localparam int AW = $clog2(MEM_WORDS);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MHARTID = 12'hF14;

   logic [31:0] pc;
   logic [31:0] rs  [0:31];
   logic [31:0] csr [0:4095];

   logic [31:0] instr, dword;
   logic [6:0]  opcode;
   logic [4:0]  rd, rs1_a, rs2_a;
   logic [2:0]  funct3;
   logic [11:0] csr_addr;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] rv1, rv2, pc4;
   logic [31:0] alu_b, alu_y, ls_addr, load_val;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [4:0]  shamt;
   logic        is_sub, br_taken;
   logic [31:0] csr_old, csr_src;

   logic [31:0] next_pc, rd_wd, csr_wd, mem_wdata, trap_cause;
   logic        rd_we, csr_we, mem_we, trap;
   logic [3:0]  mem_be;

   // Address bits above the memory index only wrap; collect them so they are visibly consumed.
   logic addr_unused;
   assign addr_unused = ^ls_addr[31:AW+2];

   rv32i_single_cycle_core_mem #(.WORDS(MEM_WORDS), .AW(AW)) memory (
      .clk   (clk),
      .iaddr (pc[AW+1:2]),
      .idata (instr),
      .daddr (ls_addr[AW+1:2]),
      .rdata (dword),
      .we    (mem_we),
      .be    (mem_be),
      .wdata (mem_wdata)
   );

   assign opcode   = instr[6:0];
   assign rd       = instr[11:7];
   assign funct3   = instr[14:12];
   assign rs1_a    = instr[19:15];
   assign rs2_a    = instr[24:20];
   assign csr_addr = instr[31:20];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'h000};
   assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

   assign rv1 = rs[rs1_a];
   assign rv2 = rs[rs2_a];
   assign pc4 = pc + 32'd4;

   assign ls_addr = rv1 + ((opcode == OP_STORE) ? imm_s : imm_i);
   assign csr_old = (csr_addr == CSR_MHARTID) ? 32'h0 : csr[csr_addr];
   assign csr_src = funct3[2] ? {27'h0, rs1_a} : rv1;

   // ALU shared by register and immediate forms; SUB only exists in the register form.
   always_comb begin
      alu_b  = (opcode == OP_REG) ? rv2 : imm_i;
      shamt  = alu_b[4:0];
      is_sub = (opcode == OP_REG) && instr[30];
      alu_y  = 32'h0;
      case (funct3)
         3'b000:  alu_y = is_sub ? (rv1 - alu_b) : (rv1 + alu_b);
         3'b001:  alu_y = rv1 << shamt;
         3'b010:  alu_y = {31'h0, $signed(rv1) < $signed(alu_b)};
         3'b011:  alu_y = {31'h0, rv1 < alu_b};
         3'b100:  alu_y = rv1 ^ alu_b;
         3'b101:  alu_y = instr[30] ? 32'($signed(rv1) >>> shamt) : (rv1 >> shamt);
         3'b110:  alu_y = rv1 | alu_b;
         default: alu_y = rv1 & alu_b;
      endcase
   end

   // Load lane extraction: address bits [1:0] pick the byte/halfword inside the word.
   always_comb begin
      ld_byte = 8'h0;
      case (ls_addr[1:0])
         2'b00:   ld_byte = dword[7:0];
         2'b01:   ld_byte = dword[15:8];
         2'b10:   ld_byte = dword[23:16];
         default: ld_byte = dword[31:24];
      endcase
      ld_half  = ls_addr[1] ? dword[31:16] : dword[15:0];
      load_val = dword;
      case (funct3)
         3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
         3'b100:  load_val = {24'h0, ld_byte};
         3'b101:  load_val = {16'h0, ld_half};
         default: load_val = dword;
      endcase
   end

   // Branch condition evaluation; reserved funct3 codes never branch.
   always_comb begin
      br_taken = 1'b0;
      case (funct3)
         3'b000:  br_taken = (rv1 == rv2);
         3'b001:  br_taken = (rv1 != rv2);
         3'b100:  br_taken = ($signed(rv1) < $signed(rv2));
         3'b101:  br_taken = ($signed(rv1) >= $signed(rv2));
         3'b110:  br_taken = (rv1 < rv2);
         3'b111:  br_taken = (rv1 >= rv2);
         default: br_taken = 1'b0;
      endcase
   end

   // Main decode: next pc, register/CSR/memory write enables and data. Unknown opcodes fall through as no-ops.
   always_comb begin
      next_pc    = pc4;
      rd_we      = 1'b0;
      rd_wd      = alu_y;
      csr_we     = 1'b0;
      csr_wd     = csr_old;
      mem_we     = 1'b0;
      mem_be     = 4'b0000;
      mem_wdata  = rv2;
      trap       = 1'b0;
      trap_cause = 32'h0;
      case (opcode)
         OP_LUI: begin
            rd_we = 1'b1;
            rd_wd = imm_u;
         end
         OP_AUIPC: begin
            rd_we = 1'b1;
            rd_wd = pc + imm_u;
         end
         OP_JAL: begin
            rd_we   = 1'b1;
            rd_wd   = pc4;
            next_pc = pc + imm_j;
         end
         OP_JALR: begin
            rd_we   = 1'b1;
            rd_wd   = pc4;
            next_pc = (rv1 + imm_i) & ~32'h1;
         end
         OP_BRANCH: begin
            if (br_taken) next_pc = pc + imm_b;
         end
         OP_LOAD: begin
            rd_we = 1'b1;
            rd_wd = load_val;
         end
         OP_STORE: begin
            mem_we = 1'b1;
            case (funct3[1:0])
               2'b00: begin
                  mem_wdata = {4{rv2[7:0]}};
                  mem_be    = 4'b0001 << ls_addr[1:0];
               end
               2'b01: begin
                  mem_wdata = {2{rv2[15:0]}};
                  mem_be    = ls_addr[1] ? 4'b1100 : 4'b0011;
               end
               default: begin
                  mem_wdata = rv2;
                  mem_be    = 4'b1111;
               end
            endcase
         end
         OP_IMM, OP_REG: begin
            rd_we = 1'b1;
            rd_wd = alu_y;
         end
         OP_SYSTEM: begin
            if (funct3 == 3'b000) begin
               case (csr_addr)
                  12'h000: begin
                     trap       = 1'b1;
                     trap_cause = 32'd11;
                  end
                  12'h001: begin
                     trap       = 1'b1;
                     trap_cause = 32'd3;
                  end
                  12'h302: next_pc = csr[CSR_MEPC];
                  default: next_pc = pc4;
               endcase
               if (trap) next_pc = csr[CSR_MTVEC];
            end else if (funct3[1:0] != 2'b00) begin
               rd_we = 1'b1;
               rd_wd = csr_old;
               case (funct3[1:0])
                  2'b01:   csr_wd = csr_src;
                  2'b10:   csr_wd = csr_old | csr_src;
                  default: csr_wd = csr_old & ~csr_src;
               endcase
               csr_we = ((funct3[1:0] == 2'b01) || (rs1_a != 5'd0)) &&
                        (csr_addr != CSR_MHARTID);
            end
         end
         default: next_pc = pc4;
      endcase
   end

   // pc and register file; x0 is never written so it always reads zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= RESET_PC;
         for (int i = 0; i < 32; i++) rs[i] <= 32'h0;
      end else begin
         pc <= next_pc;
         if (rd_we && (rd != 5'd0)) rs[rd] <= rd_wd;
      end
   end

   // CSR storage; a trap's mepc/mcause update takes priority over an explicit CSR write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4096; i++) csr[i] <= 32'h0;
      end else if (trap) begin
         csr[CSR_MEPC]   <= pc;
         csr[CSR_MCAUSE] <= trap_cause;
      end else if (csr_we) begin
         csr[csr_addr] <= csr_wd;
      end
   end
endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// Directed bench for rv32i_single_cycle_core: short programs are preloaded
// into the private memory while reset is held, the core is released for a
// fixed number of clocks, then architectural state is compared against
// hand-computed values.
module tb_rv32i_single_cycle_core;
   localparam logic [6:0] OPI = 7'h13, OPR = 7'h33, LD = 7'h03, ST = 7'h23;
   localparam logic [6:0] BR = 7'h63, LUI = 7'h37, AUIPC = 7'h17, JALR = 7'h67;
   localparam logic [6:0] SYS = 7'h73;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      string           name;
      logic [5:0][31:0] prog;
      int              cycles;
      int              chk_reg;
      logic [31:0]     exp_reg;
      logic [31:0]     exp_pc;
   } vec_t;

   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;
   logic [31:0] exp_q[$];
   vec_t vecs[$];

   rv32i_single_cycle_core dut (
      .clk (clk),
      .rst (rst)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // instruction encoders
   function automatic logic [31:0] f_i(input logic [31:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd,
                                       input logic [6:0] op);
      return {imm[11:0], rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] f_r(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, OPR};
   endfunction
   function automatic logic [31:0] f_s(input logic [31:0] imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], ST};
   endfunction
   function automatic logic [31:0] f_b(input logic [31:0] imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], BR};
   endfunction
   function automatic logic [31:0] f_u(input logic [19:0] imm, input logic [4:0] rd,
                                       input logic [6:0] op);
      return {imm, rd, op};
   endfunction
   function automatic logic [31:0] f_j(input logic [31:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
   endfunction
   function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [31:0] imm);
      return f_i(imm, rs1, 3'd0, rd, OPI);
   endfunction

   function automatic vec_t mk(input string n, input logic [31:0] a, b, c, d, e, f,
                               input int cyc, input int r, input logic [31:0] er,
                               input logic [31:0] ep);
      vec_t v;
      v.name = n;
      v.prog[0] = a; v.prog[1] = b; v.prog[2] = c;
      v.prog[3] = d; v.prog[4] = e; v.prog[5] = f;
      v.cycles = cyc; v.chk_reg = r; v.exp_reg = er; v.exp_pc = ep;
      return v;
   endfunction

   // scoreboard compare
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // driver tasks
   task automatic prep();
      rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 256; i++) dut.memory.m[i] <= 32'h0;
   endtask
   task automatic poke(input int idx, input logic [31:0] val);
      dut.memory.m[idx] <= val;
   endtask
   task automatic go();
      @(negedge clk);
      rst = 1'b0;
   endtask
   task automatic run(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      #1;
      check("reset_pc", dut.pc, 32'h0);
      check("reset_x1", dut.rs[1], 32'h0);

      // stimulus table
      vecs.push_back(mk("addi_x2", addi(1,0,5), addi(2,1,-7), NOP, NOP, NOP, NOP, 2, 2, 32'hFFFF_FFFE, 32'h8));
      vecs.push_back(mk("addi_x1", addi(1,0,5), addi(2,1,-7), NOP, NOP, NOP, NOP, 2, 1, 32'h5, 32'h8));
      vecs.push_back(mk("xor", f_u(20'hFF010,1,LUI), addi(1,1,-256), f_u(20'h0F0F1,2,LUI), addi(2,2,-241),
                        f_r(7'h00,2,1,3'd4,3), NOP, 5, 3, 32'hF00F_F00F, 32'h14));
      vecs.push_back(mk("srai", f_u(20'hFF010,1,LUI), addi(1,1,-256), f_i(32'h404,1,3'd5,4,OPI),
                        NOP, NOP, NOP, 3, 4, 32'hFFF0_0FF0, 32'hC));
      vecs.push_back(mk("srli", f_u(20'hFF010,1,LUI), addi(1,1,-256), f_i(32'h004,1,3'd5,4,OPI),
                        NOP, NOP, NOP, 3, 4, 32'h0FF0_0FF0, 32'hC));
      vecs.push_back(mk("sra_reg", f_u(20'hFF010,1,LUI), addi(1,1,-256), addi(2,0,36),
                        f_r(7'h20,2,1,3'd5,4), NOP, NOP, 4, 4, 32'hFFF0_0FF0, 32'h10));
      vecs.push_back(mk("sub", addi(1,0,3), addi(2,0,5), f_r(7'h20,2,1,3'd0,3), NOP, NOP, NOP, 3, 3, 32'hFFFF_FFFE, 32'hC));
      vecs.push_back(mk("slt", addi(1,0,-1), addi(2,0,1), f_r(7'h00,2,1,3'd2,3), NOP, NOP, NOP, 3, 3, 32'h1, 32'hC));
      vecs.push_back(mk("sltu", addi(1,0,-1), addi(2,0,1), f_r(7'h00,2,1,3'd3,3), NOP, NOP, NOP, 3, 3, 32'h0, 32'hC));
      vecs.push_back(mk("sll_shamt", addi(1,0,1), addi(2,0,33), f_r(7'h00,2,1,3'd1,3), NOP, NOP, NOP, 3, 3, 32'h2, 32'hC));
      vecs.push_back(mk("ori_andi", addi(1,0,32'hF0), f_i(32'h00F,1,3'd6,2,OPI), f_i(32'h03C,2,3'd7,3,OPI),
                        NOP, NOP, NOP, 3, 3, 32'h3C, 32'hC));
      vecs.push_back(mk("sltiu", addi(1,0,5), f_i(32'hFFF,1,3'd3,2,OPI), NOP, NOP, NOP, NOP, 2, 2, 32'h1, 32'h8));
      vecs.push_back(mk("auipc", NOP, f_u(20'h00001,5,AUIPC), NOP, NOP, NOP, NOP, 2, 5, 32'h1004, 32'h8));
      vecs.push_back(mk("lb_mid", f_u(20'h12345,1,LUI), f_s(32'h100,1,0,3'd2), f_i(32'h101,0,3'd0,2,LD),
                        f_i(32'h102,0,3'd5,3,LD), NOP, NOP, 4, 2, 32'h50, 32'h10));
      vecs.push_back(mk("lhu_hi", f_u(20'h12345,1,LUI), f_s(32'h100,1,0,3'd2), f_i(32'h101,0,3'd0,2,LD),
                        f_i(32'h102,0,3'd5,3,LD), NOP, NOP, 4, 3, 32'h1234, 32'h10));
      vecs.push_back(mk("lb_sign", addi(1,0,-128), f_s(32'h101,1,0,3'd0), f_i(32'h101,0,3'd0,2,LD),
                        NOP, NOP, NOP, 3, 2, 32'hFFFF_FF80, 32'hC));
      vecs.push_back(mk("lbu", addi(1,0,-128), f_s(32'h101,1,0,3'd0), f_i(32'h101,0,3'd4,2,LD),
                        NOP, NOP, NOP, 3, 2, 32'h80, 32'hC));
      vecs.push_back(mk("lh_sign", addi(1,0,-128), f_s(32'h101,1,0,3'd0), f_i(32'h100,0,3'd1,2,LD),
                        NOP, NOP, NOP, 3, 2, 32'hFFFF_8000, 32'hC));
      vecs.push_back(mk("lw", addi(1,0,-128), f_s(32'h104,1,0,3'd2), f_i(32'h104,0,3'd2,2,LD),
                        NOP, NOP, NOP, 3, 2, 32'hFFFF_FF80, 32'hC));
      vecs.push_back(mk("bltu_jal", addi(1,0,-1), f_b(32'h8,1,0,3'd6), addi(2,0,1), f_j(32'h8,5),
                        NOP, NOP, 3, 5, 32'h10, 32'h14));
      vecs.push_back(mk("bltu_skip", addi(1,0,-1), f_b(32'h8,1,0,3'd6), addi(2,0,1), f_j(32'h8,5),
                        NOP, NOP, 3, 2, 32'h0, 32'h14));
      vecs.push_back(mk("beq_not", addi(1,0,-1), f_b(32'h8,1,0,3'd0), addi(2,0,7), NOP, NOP, NOP, 3, 2, 32'h7, 32'hC));
      vecs.push_back(mk("bge_taken", addi(1,0,-1), f_b(32'h8,1,0,3'd5), addi(2,0,7), addi(3,0,9),
                        NOP, NOP, 3, 3, 32'h9, 32'h10));
      vecs.push_back(mk("bne_taken", addi(1,0,1), f_b(32'h8,0,1,3'd1), addi(2,0,7), addi(3,2,1),
                        NOP, NOP, 3, 3, 32'h1, 32'h10));
      vecs.push_back(mk("jalr", addi(1,0,32'h11), f_i(32'h4,1,3'd0,5,JALR), NOP, NOP, NOP, NOP, 2, 5, 32'h8, 32'h14));
      vecs.push_back(mk("x0_discard", addi(0,0,5), NOP, NOP, NOP, NOP, NOP, 1, 0, 32'h0, 32'h4));
      vecs.push_back(mk("csrrw", addi(6,0,32'h80), f_i(32'h305,6,3'd1,0,SYS), f_i(32'h305,0,3'd1,7,SYS),
                        NOP, NOP, NOP, 3, 7, 32'h80, 32'hC));
      vecs.push_back(mk("mhartid", addi(1,0,5), f_i(32'hF14,1,3'd1,0,SYS), f_i(32'hF14,0,3'd2,2,SYS),
                        NOP, NOP, NOP, 3, 2, 32'h0, 32'hC));
      vecs.push_back(mk("csr_imm", f_i(32'h340,5,3'd5,0,SYS), f_i(32'h340,2,3'd6,0,SYS), f_i(32'h340,1,3'd7,3,SYS),
                        f_i(32'h340,0,3'd2,4,SYS), NOP, NOP, 4, 4, 32'h6, 32'h10));
      vecs.push_back(mk("csrrci_old", f_i(32'h340,5,3'd5,0,SYS), f_i(32'h340,2,3'd6,0,SYS), f_i(32'h340,1,3'd7,3,SYS),
                        f_i(32'h340,0,3'd2,4,SYS), NOP, NOP, 4, 3, 32'h7, 32'h10));
      vecs.push_back(mk("csrrs_x0", addi(1,0,9), f_i(32'h340,1,3'd1,0,SYS), f_i(32'h340,0,3'd3,0,SYS),
                        f_i(32'h340,0,3'd2,4,SYS), NOP, NOP, 4, 4, 32'h9, 32'h10));
      vecs.push_back(mk("fence", 32'h0000_000F, addi(1,0,3), NOP, NOP, NOP, NOP, 2, 1, 32'h3, 32'h8));

      foreach (vecs[k]) begin
         prep();
         for (int i = 0; i < 6; i++) poke(i, vecs[k].prog[i]);
         exp_q.push_back(vecs[k].exp_reg);
         exp_q.push_back(vecs[k].exp_pc);
         go();
         run(vecs[k].cycles);
         check({vecs[k].name, "_rd"}, dut.rs[vecs[k].chk_reg], exp_q.pop_front());
         check({vecs[k].name, "_pc"}, dut.pc, exp_q.pop_front());
      end

      // store lanes: sw, then sh upper half, then sb byte 1; other bytes preserved
      prep();
      poke(0, f_u(20'h12345,1,LUI));
      poke(1, f_s(32'h100,1,0,3'd2));
      poke(2, addi(2,0,-1));
      poke(3, f_s(32'h102,2,0,3'd1));
      poke(4, f_s(32'h101,0,0,3'd0));
      go();
      run(2);
      check("sw_word", dut.memory.m[32'h40], 32'h1234_5000);
      run(2);
      check("sh_upper", dut.memory.m[32'h40], 32'hFFFF_5000);
      run(1);
      check("sb_byte1", dut.memory.m[32'h40], 32'hFFFF_0000);

      // ecall at 0x40 through mtvec=0x80, then mret back; words 2..15 are undecoded zeros
      prep();
      poke(0, addi(6,0,32'h80));
      poke(1, f_i(32'h305,6,3'd1,0,SYS));
      poke(16, 32'h0000_0073);
      poke(32, 32'h3020_0073);
      go();
      run(17);
      check("ecall_pc", dut.pc, 32'h80);
      check("ecall_mepc", dut.csr[12'h341], 32'h40);
      check("ecall_mcause", dut.csr[12'h342], 32'd11);
      run(1);
      check("mret_pc", dut.pc, 32'h40);

      // reset clears CSRs and pc while asserted
      prep();
      check("rst_mtvec", dut.csr[12'h305], 32'h0);
      check("rst_mepc", dut.csr[12'h341], 32'h0);
      check("rst_pc", dut.pc, 32'h0);

      // ebreak
      poke(0, addi(6,0,32'h20));
      poke(1, f_i(32'h305,6,3'd1,0,SYS));
      poke(2, 32'h0010_0073);
      go();
      run(3);
      check("ebreak_pc", dut.pc, 32'h20);
      check("ebreak_mepc", dut.csr[12'h341], 32'h8);
      check("ebreak_mcause", dut.csr[12'h342], 32'd3);

      // counting loop interrupted by an asynchronous reset
      prep();
      poke(0, addi(1,1,1));
      poke(1, f_j(-32'sd4, 0));
      go();
      run(7);
      check("loop_x1", dut.rs[1], 32'h4);
      check("loop_pc", dut.pc, 32'h4);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_pc", dut.pc, 32'h0);
      check("midrst_x1", dut.rs[1], 32'h0);
      @(negedge clk);
      rst = 1'b0;
      run(3);
      check("restart_x1", dut.rs[1], 32'h2);
      check("restart_pc", dut.pc, 32'h4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
